// File: rtl/outpkt_multiword_pkg.sv
// Shared pkt_comm constants for the multi-word 0x81 packet builder.
// `MSB(x) gives the bit index of the MSB needed to hold the value x.
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package outpkt_multiword_pkg;

    localparam int HDR = 5;

    localparam logic [2:0] K_TYPE   = 3'd0;
    localparam logic [2:0] K_CSUM   = 3'd1;
    localparam logic [2:0] K_LEN_LO = 3'd2;
    localparam logic [2:0] K_LEN_HI = 3'd3;
    localparam logic [2:0] K_ID     = 3'd4;

    localparam logic [7:0] PKT_TYPE_WORD   = 8'h81;
    localparam logic [7:0] PKT_VERSION_DEF = 8'h01;

    typedef enum logic {
        S_FILL = 1'b0,
        S_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/outpkt_record_fmt.sv
// Maps offset m within one record to its 16-bit data word:
// two 7-bit chars per word first, then the 16-bit ID words.
module outpkt_record_fmt #(
    parameter int CHARS    = 8,
    parameter int ID_WORDS = 3,
    parameter int M_W      = 3
) (
    input  logic [CHARS*7+ID_WORDS*16-1:0] rec,
    input  logic [M_W-1:0]                 m,
    output logic [15:0]                    word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < CHARS / 2; i++) begin
            if (m == M_W'(i)) word = {1'b0, rec[14*i+7 +: 7], 1'b0, rec[14*i +: 7]};
        end
        for (int i = 0; i < ID_WORDS; i++) begin
            if (m == M_W'(CHARS / 2 + i)) word = rec[CHARS*7 + 16*i +: 16];
        end
    end

endmodule

// File: rtl/outpkt_multiword.sv
// Batches result records into 0x81 packets and streams them as 16-bit FWFT words.
// Optional OUTPKT_CHECKSUM_EN: header word 1 carries ~(sum of all data words).
module outpkt_multiword
    import outpkt_multiword_pkg::*;
#(
    parameter int         CHARS        = 8,
    parameter int         ID_WORDS     = 3,
    parameter int         RECS_PER_PKT = 4,
    parameter logic [7:0] PKT_TYPE     = PKT_TYPE_WORD,
    parameter logic [7:0] PKT_VERSION  = PKT_VERSION_DEF,
    parameter int         TIMEOUT      = 1024
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [CHARS*7+ID_WORDS*16-1:0] din,
    input  logic [15:0]                    pkt_id,
    input  logic                           wr_en,
    output logic                           full,
    output logic [15:0]                    dout,
    output logic                           pkt_new,
    output logic                           pkt_end,
    input  logic                           rd_en,
    output logic                           empty
);

    localparam int R        = CHARS / 2 + ID_WORDS;
    localparam int REC_W    = CHARS * 7 + ID_WORDS * 16;
    localparam int LAST_MAX = HDR + RECS_PER_PKT * R - 1;
    localparam int K_W      = `MSB(LAST_MAX) + 1;
    localparam int N_W      = `MSB(RECS_PER_PKT) + 1;
    localparam int M_W      = `MSB(R) + 1;
    localparam int S_W      = (RECS_PER_PKT > 1) ? $clog2(RECS_PER_PKT) : 1;
    localparam int T_W      = `MSB((TIMEOUT > 0) ? TIMEOUT : 1) + 1;

    // Handshake: din is taken at a clock edge when wr_en & ~full; dout is valid
    // while ~empty and is consumed at the edge where rd_en & ~empty.
    state_t           state, state_d;
    logic [N_W-1:0]   n, n_d;
    logic [K_W-1:0]   k, k_d, last_k;
    logic [S_W-1:0]   r, r_d;
    logic [M_W-1:0]   m, m_d;
    logic [T_W-1:0]   cnt, cnt_d;
    logic [15:0]      id_q, id_d;
    logic [15:0]      data_word, csum_word;
    logic             go_send;
    logic [REC_W-1:0] buf_q [2**S_W];

    assign last_k = K_W'(HDR - 1) + K_W'(n) * K_W'(R);

    always_comb begin
        state_d = state;
        n_d     = n;
        k_d     = k;
        r_d     = r;
        m_d     = m;
        cnt_d   = cnt;
        id_d    = id_q;
        go_send = 1'b0;
        case (state)
            S_FILL: begin
                cnt_d = (n == '0) ? '0 : cnt + T_W'(1);
                if (wr_en) begin
                    n_d = n + N_W'(1);
                    if (n == N_W'(RECS_PER_PKT - 1)) go_send = 1'b1;
                end
                // A write landing in the timeout cycle still joins this batch.
                if (TIMEOUT != 0 && n != '0 && cnt == T_W'(TIMEOUT - 1)) go_send = 1'b1;
                if (go_send) begin
                    state_d = S_SEND;
                    id_d    = pkt_id;
                    cnt_d   = '0;
                end
            end
            S_SEND: begin
                if (rd_en) begin
                    if (k == last_k) begin
                        state_d = S_FILL;
                        n_d     = '0;
                        k_d     = '0;
                        r_d     = '0;
                        m_d     = '0;
                    end else begin
                        k_d = k + K_W'(1);
                        if (k >= K_W'(HDR)) begin
                            if (m == M_W'(R - 1)) begin
                                m_d = '0;
                                r_d = r + S_W'(1);
                            end else begin
                                m_d = m + M_W'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_FILL;
            n     <= '0;
            k     <= '0;
            r     <= '0;
            m     <= '0;
            cnt   <= '0;
            id_q  <= '0;
        end else begin
            state <= state_d;
            n     <= n_d;
            k     <= k_d;
            r     <= r_d;
            m     <= m_d;
            cnt   <= cnt_d;
            id_q  <= id_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == S_FILL && wr_en) buf_q[n[S_W-1:0]] <= din;
    end

    outpkt_record_fmt #(.CHARS(CHARS), .ID_WORDS(ID_WORDS), .M_W(M_W)) u_fmt (
        .rec  (buf_q[r]),
        .m    (m),
        .word (data_word)
    );

`ifdef OUTPKT_CHECKSUM_EN
    logic [15:0] csum_q, csum_d, rec_sum;
    logic [15:0] din_word [R];

    for (genvar g = 0; g < R; g++) begin : g_sum
        outpkt_record_fmt #(.CHARS(CHARS), .ID_WORDS(ID_WORDS), .M_W(M_W)) u_fmt_sum (
            .rec  (din),
            .m    (M_W'(g)),
            .word (din_word[g])
        );
    end

    always_comb begin
        rec_sum = '0;
        for (int i = 0; i < R; i++) rec_sum = rec_sum + din_word[i];
    end

    always_comb begin
        csum_d = csum_q;
        if (state == S_FILL && wr_en) csum_d = csum_q + rec_sum;
        else if (state == S_SEND && rd_en && k == last_k) csum_d = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign csum_word = ~csum_q;
`else
    assign csum_word = 16'h0000;
`endif

    always_comb begin
        dout = '0;
        if (state == S_SEND) begin
            if (k < K_W'(HDR)) begin
                case (k[2:0])
                    K_TYPE:   dout = {PKT_TYPE, PKT_VERSION};
                    K_CSUM:   dout = csum_word;
                    K_LEN_LO: dout = 16'(n) * 16'(2 * R);
                    K_LEN_HI: dout = '0;
                    K_ID:     dout = id_q;
                    default:  dout = '0;
                endcase
            end else begin
                dout = data_word;
            end
        end
    end

    assign full    = (state == S_SEND);
    assign empty   = (state != S_SEND);
    assign pkt_new = (state == S_SEND) && (k == '0);
    assign pkt_end = (state == S_SEND) && (k == last_k);

endmodule

// File: tb/tb_outpkt_multiword.sv
// Directed bench for outpkt_multiword (RECS_PER_PKT=4, TIMEOUT=16).
// Build with +define+OUTPKT_CHECKSUM_EN to cover the checksum header word.
`timescale 1ns/1ps
module tb_outpkt_multiword;

    localparam int CHARS = 8;
    localparam int IDW   = 3;
    localparam int RECS  = 4;
    localparam int TMO   = 16;
    localparam int R     = CHARS / 2 + IDW;
    localparam int REC_W = CHARS * 7 + IDW * 16;

    logic             CLK;
    logic             RST_N;
    logic [REC_W-1:0] din;
    logic [15:0]      pkt_id;
    logic             wr_en;
    logic             full;
    logic [15:0]      dout;
    logic             pkt_new;
    logic             pkt_end;
    logic             rd_en;
    logic             empty;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0]  mc [8][CHARS];
    logic [15:0] mi [8][IDW];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    logic [2:0]  flg_q [$];
    bit          drain_ok;

    outpkt_multiword #(
        .CHARS(CHARS), .ID_WORDS(IDW), .RECS_PER_PKT(RECS),
        .PKT_TYPE(8'h81), .PKT_VERSION(8'h01), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .din(din), .pkt_id(pkt_id), .wr_en(wr_en),
        .full(full), .dout(dout), .pkt_new(pkt_new), .pkt_end(pkt_end),
        .rd_en(rd_en), .empty(empty)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Driver tasks
    function automatic logic [REC_W-1:0] pack_rec(int idx);
        logic [REC_W-1:0] v;
        v = '0;
        for (int i = 0; i < CHARS; i++) v[7*i +: 7] = mc[idx][i];
        for (int i = 0; i < IDW; i++) v[CHARS*7 + 16*i +: 16] = mi[idx][i];
        return v;
    endfunction

    task automatic write_rec(int idx);
        din   = pack_rec(idx);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic set_rec(int idx, int cbase, int ibase);
        for (int i = 0; i < CHARS; i++) mc[idx][i] = 7'(cbase + i);
        for (int i = 0; i < IDW; i++) mi[idx][i] = 16'(16'h1111 * (i + 1) + ibase);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        got_q.delete();
        flg_q.delete();
        for (int c = 0; c < 200 && !done; c++) begin
            if (!empty) begin
                got_q.push_back(dout);
                flg_q.push_back({pkt_new, pkt_end, full});
                done  = pkt_end;
                rd_en = 1'b1;
            end
            tick();
            rd_en = 1'b0;
        end
        drain_ok = done;
    endtask

    task automatic wait_send(output int cycles);
        cycles = 0;
        while (empty && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    // Scoreboard model: expected word stream for records base..base+n-1
    function automatic void build_exp(int base, int n, logic [15:0] pid);
        logic [15:0] data_q [$];
        logic [15:0] sum;
        logic [15:0] w;
        sum = '0;
        for (int rr = base; rr < base + n; rr++) begin
            for (int mm = 0; mm < CHARS / 2; mm++) begin
                w = {1'b0, mc[rr][2*mm+1], 1'b0, mc[rr][2*mm]};
                data_q.push_back(w);
                sum += w;
            end
            for (int i = 0; i < IDW; i++) begin
                data_q.push_back(mi[rr][i]);
                sum += mi[rr][i];
            end
        end
        exp_q.delete();
        exp_q.push_back(16'h8101);
`ifdef OUTPKT_CHECKSUM_EN
        exp_q.push_back(~sum);
`else
        exp_q.push_back(16'h0000);
`endif
        exp_q.push_back(16'(n * R * 2));
        exp_q.push_back(16'h0000);
        exp_q.push_back(pid);
        foreach (data_q[i]) exp_q.push_back(data_q[i]);
    endfunction

    task automatic test_reset();
        RST_N  = 1'b0;
        din    = '0;
        pkt_id = '0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        tick();
        tick();
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_vec++; if (pkt_new !== 1'b0) begin n_err++; $display("FAIL reset_pkt_new got %b exp 0", pkt_new); end
        n_vec++; if (pkt_end !== 1'b0) begin n_err++; $display("FAIL reset_pkt_end got %b exp 0", pkt_end); end
        n_vec++; if (dout !== 16'h0000) begin n_err++; $display("FAIL reset_dout got %h exp 0000", dout); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_fill_full();
        logic [2:0] ef;
        pkt_id = 16'hA5A5;
        for (int i = 0; i < RECS; i++) set_rec(i, i * 16 + 1, i);
        for (int i = 0; i < RECS - 1; i++) write_rec(i);
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_early got %b exp 0", full); end
        write_rec(RECS - 1);
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full_set got %b exp 1", full); end
        n_vec++; if (pkt_new !== 1'b1) begin n_err++; $display("FAIL fill_pkt_new got %b exp 1", pkt_new); end
        // a write while full must be ignored
        din   = '1;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        drain();
        build_exp(0, RECS, 16'hA5A5);
        n_vec++;
        if (!drain_ok || got_q.size() != 33) begin
            n_err++; $display("FAIL fill_words got %0d exp 33 (end seen %0d)", got_q.size(), drain_ok);
        end
        n_vec++; if (got_q[2] !== 16'h0038) begin n_err++; $display("FAIL fill_len got %h exp 0038", got_q[2]); end
        n_vec++; if (got_q[5] !== 16'h0201) begin n_err++; $display("FAIL fill_w5 got %h exp 0201", got_q[5]); end
        n_vec++; if (got_q[9] !== 16'h1111) begin n_err++; $display("FAIL fill_w9 got %h exp 1111", got_q[9]); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            ef = {1'(i == 0), 1'(i == exp_q.size() - 1), 1'b1};
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fill_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
            n_vec++;
            if (flg_q[i] !== ef) begin n_err++; $display("FAIL fill_flags[%0d] got %b exp %b", i, flg_q[i], ef); end
        end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_drop got %b exp 0", full); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty_after got %b exp 1", empty); end
    endtask

    task automatic test_timeout();
        int cyc;
        pkt_id = 16'h1234;
        set_rec(0, 33, 7);
        write_rec(0);
        // rd_en while empty must not advance the index
        rd_en = 1'b1;
        wait_send(cyc);
        rd_en = 1'b0;
        n_vec++; if (cyc != 16) begin n_err++; $display("FAIL timeout_cycles got %0d exp 16", cyc); end
        drain();
        build_exp(0, 1, 16'h1234);
        n_vec++;
        if (!drain_ok || got_q.size() != 12) begin n_err++; $display("FAIL timeout_words got %0d exp 12", got_q.size()); end
        n_vec++; if (got_q[2] !== 16'h000E) begin n_err++; $display("FAIL timeout_len got %h exp 000e", got_q[2]); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL timeout_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout_write();
        pkt_id = 16'h5678;
        set_rec(0, 70, 3);
        set_rec(1, 90, 5);
        write_rec(0);
        for (int i = 0; i < TMO - 1; i++) tick();
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL tw_still_fill got %b exp 1", empty); end
        write_rec(1);
        n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL tw_send got %b exp 0", empty); end
        drain();
        build_exp(0, 2, 16'h5678);
        n_vec++;
        if (!drain_ok || got_q.size() != 19) begin n_err++; $display("FAIL tw_words got %0d exp 19", got_q.size()); end
        n_vec++; if (got_q[2] !== 16'h001C) begin n_err++; $display("FAIL tw_len got %h exp 001c", got_q[2]); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL tw_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int          cyc;
        int          idx;
        bit          held;
        bit          done;
        bit          rd;
        logic [17:0] hold;
        logic [1:0]  ef;
        pkt_id = 16'hBEEF;
        set_rec(0, 5, 9);
        set_rec(1, 100, 11);
        write_rec(0);
        write_rec(1);
        wait_send(cyc);
        build_exp(0, 2, 16'hBEEF);
        idx  = 0;
        held = 1'b0;
        done = 1'b0;
        hold = '0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (empty) begin
                n_vec++; n_err++;
                $display("FAIL bp_underrun got empty=1 exp 0 at word %0d", idx);
                break;
            end
            if (held) begin
                n_vec++;
                if ({dout, pkt_new, pkt_end} !== hold) begin
                    n_err++; $display("FAIL bp_stable got %h exp %h", {dout, pkt_new, pkt_end}, hold);
                end
            end
            rd    = 1'($urandom_range(0, 1));
            rd_en = rd;
            if (rd) begin
                ef = {1'(idx == 0), 1'(idx == exp_q.size() - 1)};
                n_vec++;
                if (idx >= exp_q.size() || dout !== exp_q[idx]) begin
                    n_err++; $display("FAIL bp_word[%0d] got %h exp %h", idx, dout, exp_q[idx]);
                end
                n_vec++;
                if ({pkt_new, pkt_end} !== ef) begin
                    n_err++; $display("FAIL bp_flags[%0d] got %b exp %b", idx, {pkt_new, pkt_end}, ef);
                end
                done = pkt_end;
                idx++;
                held = 1'b0;
            end else begin
                hold = {dout, pkt_new, pkt_end};
                held = 1'b1;
            end
            tick();
            rd_en = 1'b0;
        end
        n_vec++;
        if (!done || idx != exp_q.size()) begin n_err++; $display("FAIL bp_count got %0d exp %0d", idx, exp_q.size()); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL bp_empty_after got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid_send();
        int cyc;
        pkt_id = 16'h4242;
        for (int i = 0; i < RECS; i++) set_rec(i, i * 8 + 2, i + 20);
        for (int i = 0; i < RECS; i++) write_rec(i);
        rd_en = 1'b1;
        repeat (10) tick();
        rd_en = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty got %b exp 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_mid_full got %b exp 0", full); end
        n_vec++; if (dout !== 16'h0000) begin n_err++; $display("FAIL rst_mid_dout got %h exp 0000", dout); end
        tick();
        RST_N  = 1'b1;
        tick();
        pkt_id = 16'h0F0F;
        write_rec(2);
        wait_send(cyc);
        drain();
        build_exp(2, 1, 16'h0F0F);
        n_vec++;
        if (!drain_ok || got_q.size() != 12) begin n_err++; $display("FAIL rst_next_words got %0d exp 12", got_q.size()); end
        n_vec++; if (got_q[0] !== 16'h8101) begin n_err++; $display("FAIL rst_next_w0 got %h exp 8101", got_q[0]); end
        n_vec++; if (got_q[2] !== 16'h000E) begin n_err++; $display("FAIL rst_next_len got %h exp 000e", got_q[2]); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_next_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_checksum();
        int          cyc;
        logic [15:0] exp_cs;
`ifdef OUTPKT_CHECKSUM_EN
        exp_cs = 16'hFFF9;
`else
        exp_cs = 16'h0000;
`endif
        pkt_id = 16'h0001;
        for (int i = 0; i < CHARS; i++) mc[0][i] = 7'h00;
        mi[0][0] = 16'h0001;
        mi[0][1] = 16'h0002;
        mi[0][2] = 16'h0003;
        write_rec(0);
        wait_send(cyc);
        drain();
        n_vec++;
        if (!drain_ok || got_q.size() != 12) begin n_err++; $display("FAIL csum_words got %0d exp 12", got_q.size()); end
        n_vec++; if (got_q[1] !== exp_cs) begin n_err++; $display("FAIL csum_word got %h exp %h", got_q[1], exp_cs); end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_timeout();
        test_timeout_write();
        test_backpressure();
        test_reset_mid_send();
        test_checksum();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/outpkt_multiword.md
Name: outpkt_multiword

Overview:
- Parametrised successor of the single-record 0x81 packet builder in pkt_comm.
- Accepts result records (CHARS 7-bit characters plus ID_WORDS 16-bit IDs) from the wide result bus.
- Batches up to RECS_PER_PKT records into one packet, flushing a partial batch after a timeout.
- Emits the header and data as 16-bit words into the output FIFO using a FWFT handshake.

Parameters:
- CHARS, 8: characters per record; must be even; 7 bits each.
- ID_WORDS, 3: 16-bit ID words per record (word_id, gen_id, extra).
- RECS_PER_PKT, 4: maximum records per packet; range 1..16.
- PKT_TYPE, 8'h81: packet type byte.
- PKT_VERSION, 8'h01: version byte.
- TIMEOUT, 1024: flush timeout in cycles; 0 disables the flush.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- din  in  CHARS*7+ID_WORDS*16  record; chars at LSBs, char i at [7i+6:7i], IDs above
- pkt_id  in  16  packet id; sampled on entry to SEND
- wr_en  in  1  write request
- full  out  1  high: wr_en is ignored
- dout  out  16  current output word
- pkt_new  out  1  dout is the first word of a packet
- pkt_end  out  1  dout is the last word of a packet
- rd_en  in  1  consume dout
- empty  out  1  high: dout is invalid

Behaviour:
- Derived constants:
  - R = CHARS/2 + ID_WORDS (16-bit words per record).
  - HDR = 5 (header words).
  - Words per packet = HDR + n*R, where n = records in the batch (1..RECS_PER_PKT).
- Reset (RST_N low, asynchronous):
  - State goes to FILL; n=0; word index=0; timeout counter=0.
  - full=0, empty=1, pkt_new=0, pkt_end=0, dout=0.
  - A packet in progress is discarded; the buffer contents are don't-care.
- FILL state:
  - full=0, empty=1.
  - wr_en stores din into slot n, then n<=n+1.
  - When the write brings n to RECS_PER_PKT, go to SEND on the next cycle.
  - Timeout counter: cleared when n==0; otherwise increments every cycle.
  - When the counter reaches TIMEOUT-1 with n>0, go to SEND.
  - A write in the timeout cycle is accepted, included in the batch, and then SEND is entered.
- SEND state:
  - full=1, empty=0. pkt_id is latched on entry.
  - rd_en advances the word index k.
  - When the word at k = HDR+n*R-1 is consumed, go to FILL with n=0 and k=0. full drops the following cycle.
  - rd_en while empty=1 is ignored.
- dout by index:
  - k=0: {PKT_TYPE, PKT_VERSION}.
  - k=1: checksum field.
  - k=2: data length in bytes, low half (n*R*2).
  - k=3: data length high half (0).
  - k=4: pkt_id.
  - Data words, with j = k-5, record r = j/R, offset m = j%R:
    - m < CHARS/2: {1'b0, char[2m+1], 1'b0, char[2m]}.
    - Otherwise: ID word m-CHARS/2.
- Flags and outputs:
  - pkt_new = (k==0) & ~empty.
  - pkt_end = (last index) & ~empty.
  - Outputs are combinational from registers, with no combinational path from rd_en.
- Index widths are sized by `MSB of the maximum value. No wrap past the last word.

Optional Feature:
- OUTPKT_CHECKSUM_EN defined:
  - A 16-bit accumulator sums all data words of each record as it is written (mod 2^16).
  - The accumulator clears on entry to FILL and on reset.
  - Header word k=1 = bitwise NOT of the sum.
- Not defined: word k=1 = 16'h0000 and no accumulator is synthesised.

Decomposition:
- pkt_comm shared package/header holds:
  - HDR length and the header word index constants.
  - PKT_TYPE_WORD=8'h81 and PKT_VERSION default.
  - The `MSB macro.
- One sub-module: outpkt_record_fmt, a combinational mux mapping (record slot, offset m) to a 16-bit data word. It is reused by the checksum accumulator.

Test Plan:
- Fill to full: 4 writes, chars 0x01..0x08, IDs 0x1111/0x2222/0x3333.
  - Expect 33 words: 0x8101, 0x0000, 0x0038, 0x0000, pkt_id, then 0x0201, 0x0403, ... per record.
  - pkt_new on word 0 only; pkt_end on word 32; full=1 until the last word is consumed.
- Timeout flush: 1 write with TIMEOUT=16.
  - SEND entered exactly 16 cycles after the write.
  - Length word = 0x000E; 12 words total.
- Write in the timeout cycle: write at cycle 15 of the timeout window → the packet carries 2 records, length 0x001C.
- Backpressure: rd_en toggled randomly → dout/pkt_new/pkt_end stay stable while rd_en=0; no word is lost or duplicated.
- Reset mid-SEND at word 10: RST_N pulse → empty=1, full=0 immediately; the next packet starts at 0x8101 with n counted from 0.
- OUTPKT_CHECKSUM_EN: one record, all chars 0, IDs 0x0001/0x0002/0x0003 → checksum word = 0xFFF9; without the macro → 0x0000.
